// File: rtl/opo_package.sv
// -----------------------------------------------------------------------------
// opo_package
// Shared types and constants for the OPO lock datapath.
//   word_width       : signed width of ADC and reference samples
//   config_reg_width : signed width of published result words
//   LIA_MAX_LOG2     : largest averaging window exponent of the lock-in integrator
//   lia_state_t      : lock-in integrator control states (IDLE / ACCUM / DUMP)
// -----------------------------------------------------------------------------
package opo_package;

    localparam int word_width       = 16;
    localparam int config_reg_width = 32;

    localparam int LIA_MAX_LOG2 = 16;
    // Product width plus headroom for 2^LIA_MAX_LOG2 worst-case products.
    localparam int LIA_ACC_W    = 2 * word_width + LIA_MAX_LOG2;
    // Mean (LIA_ACC_W bits) shifted left by up to 15 still fits here without loss.
    localparam int LIA_SCALED_W = LIA_ACC_W + 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } lia_state_t;

    // Clamp a requested window exponent to the supported range.
    function automatic logic [4:0] lia_clamp_log2(input logic [4:0] v);
        logic [4:0] r;
        if (v > 5'(LIA_MAX_LOG2)) begin
            r = 5'(LIA_MAX_LOG2);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // True when a wide signed value is representable in config_reg_width bits:
    // every bit from the output sign bit upward must equal the sign.
    function automatic logic lia_fits_out(input logic signed [LIA_SCALED_W-1:0] v);
        logic [LIA_SCALED_W-config_reg_width:0] top;
        top = v[LIA_SCALED_W-1:config_reg_width-1];
        return (top == '0) || (top == '1);
    endfunction

endpackage

// File: rtl/lia_mac_channel.sv
// -----------------------------------------------------------------------------
// lia_mac_channel
// One demodulation channel: input register (S1), signed multiply (S2),
// window accumulator (S3), and the mean/scale/limit stage that updates the
// published component while the shared FSM is in DUMP.
// Build option: LIA_SATURATE_EN -- clamp out-of-range results to the signed
// output limits; otherwise the low output bits are kept (two's-complement wrap).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   adc_data      : signed ADC sample (captured every cycle into S1)
//   ref_data      : signed reference word for this channel
//   acc_add       : add the S2 product to the running sum
//   win_end       : final product of the window: capture sum, restart acc at 0
//   acc_clr       : discard the running sum
//   dump          : update comp from the captured window sum
//   k_dump        : window exponent of the captured sum
//   g_dump        : gain shift of the captured sum
//   comp          : registered signed result
//   clip          : result being written this cycle is out of range
// -----------------------------------------------------------------------------
module lia_mac_channel
    import opo_package::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [word_width-1:0]       adc_data,
    input  logic signed [word_width-1:0]       ref_data,
    input  logic                               acc_add,
    input  logic                               win_end,
    input  logic                               acc_clr,
    input  logic                               dump,
    input  logic [4:0]                         k_dump,
    input  logic [3:0]                         g_dump,
    output logic signed [config_reg_width-1:0] comp,
    output logic                               clip
);

    localparam int PROD_W = 2 * word_width;

    logic signed [word_width-1:0]       adc_r;
    logic signed [word_width-1:0]       ref_r;
    logic signed [PROD_W-1:0]           prod_r;
    logic signed [LIA_ACC_W-1:0]        acc_r;
    logic signed [LIA_ACC_W-1:0]        sum_r;
    logic signed [LIA_ACC_W-1:0]        sum_next_s;
    logic signed [LIA_SCALED_W-1:0]     mean_s;
    logic signed [LIA_SCALED_W-1:0]     scaled_s;
    logic                               fits_s;
    logic signed [config_reg_width-1:0] result_s;

    // S1 input capture and S2 full-precision product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_r  <= '0;
            ref_r  <= '0;
            prod_r <= '0;
        end else begin
            adc_r  <= adc_data;
            ref_r  <= ref_data;
            prod_r <= PROD_W'(adc_r) * PROD_W'(ref_r);
        end
    end

    // Running sum including the current product (sign-extended to acc width).
    always_comb begin
        sum_next_s = acc_r + {{(LIA_ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
    end

    // S3 accumulator; on the last sample the complete sum is handed to sum_r
    // and acc restarts from zero so the next window loses no sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            sum_r <= '0;
        end else if (acc_clr) begin
            acc_r <= '0;
            sum_r <= sum_r;
        end else if (win_end) begin
            acc_r <= '0;
            sum_r <= sum_next_s;
        end else if (acc_add) begin
            acc_r <= sum_next_s;
            sum_r <= sum_r;
        end else begin
            acc_r <= acc_r;
            sum_r <= sum_r;
        end
    end

    // Mean is an arithmetic right shift (floor toward -inf), then gain scaling.
    always_comb begin
        mean_s   = $signed({{(LIA_SCALED_W-LIA_ACC_W){sum_r[LIA_ACC_W-1]}}, sum_r}) >>> k_dump;
        scaled_s = mean_s <<< g_dump;
        fits_s   = lia_fits_out(scaled_s);
`ifdef LIA_SATURATE_EN
        if (fits_s) begin
            result_s = scaled_s[config_reg_width-1:0];
        end else if (scaled_s[LIA_SCALED_W-1]) begin
            result_s = {1'b1, {(config_reg_width-1){1'b0}}};
        end else begin
            result_s = {1'b0, {(config_reg_width-1){1'b1}}};
        end
`else
        result_s = scaled_s[config_reg_width-1:0];
`endif
        clip = dump & ~fits_s;
    end

    // Published component; holds between windows and across enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp <= '0;
        end else if (dump) begin
            comp <= result_s;
        end else begin
            comp <= comp;
        end
    end

endmodule

// File: rtl/lock_in_integrator.sv
// -----------------------------------------------------------------------------
// lock_in_integrator
// Demodulates ADC samples against sine/cosine references and publishes the
// mean of each 2^avg_log2-sample window, scaled by 2^gain_shift.
// Build option: LIA_SATURATE_EN (see lia_mac_channel) selects clamping instead
// of wrapping for out-of-range results; overflow is flagged either way.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : 1 integrate, 0 abort window / clear accumulators / overflow
//   sample_valid  : qualifies adc_data, sine_ref, cos_ref
//   adc_data      : signed ADC sample
//   sine_ref      : signed in-phase reference
//   cos_ref       : signed quadrature reference
//   avg_log2      : window exponent (clamped to LIA_MAX_LOG2), latched per window
//   gain_shift    : output left shift, latched per window
//   real_comp     : in-phase mean x 2^gain_shift
//   imag_comp     : quadrature mean x 2^gain_shift
//   result_valid  : one-cycle pulse when real/imag update
//   overflow      : sticky out-of-range flag
// -----------------------------------------------------------------------------
module lock_in_integrator
    import opo_package::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               sample_valid,
    input  logic signed [word_width-1:0]       adc_data,
    input  logic signed [word_width-1:0]       sine_ref,
    input  logic signed [word_width-1:0]       cos_ref,
    input  logic [4:0]                         avg_log2,
    input  logic [3:0]                         gain_shift,
    output logic signed [config_reg_width-1:0] real_comp,
    output logic signed [config_reg_width-1:0] imag_comp,
    output logic                               result_valid,
    output logic                               overflow
);

    localparam int CNT_W = LIA_MAX_LOG2;

    lia_state_t        state_r;
    lia_state_t        state_next_s;
    logic              s1_valid_r;
    logic              s2_valid_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W:0]    win_mask_s;
    logic              win_last_s;
    logic              active_s;
    logic              acc_add_s;
    logic              win_end_s;
    logic              acc_clr_s;
    logic              dump_s;
    logic [4:0]        k_r;
    logic [3:0]        g_r;
    logic [4:0]        k_dump_r;
    logic [3:0]        g_dump_r;
    logic              clip_re_s;
    logic              clip_im_s;

    // Valid pipeline alongside the channel S1/S2 registers; enable low flushes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= enable & sample_valid;
            s2_valid_r <= enable & s1_valid_r;
        end
    end

    // Window bookkeeping: is the product now at S3 the last of the window?
    always_comb begin
        win_mask_s = ((CNT_W+1)'(1) << k_r) - (CNT_W+1)'(1);
        win_last_s = ({1'b0, count_r} == win_mask_s);
        active_s   = enable & (state_r != IDLE);
        acc_add_s  = active_s & s2_valid_r & ~win_last_s;
        win_end_s  = active_s & s2_valid_r & win_last_s;
        acc_clr_s  = ~active_s;
        dump_s     = enable & (state_r == DUMP);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; a window may close while DUMP is publishing the previous one.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM, DUMP: begin
                if (!enable) begin
                    state_next_s = IDLE;
                end else if (win_end_s) begin
                    state_next_s = DUMP;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Sample counter, per-window configuration latches, result strobe, overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r      <= '0;
            k_r          <= '0;
            g_r          <= '0;
            k_dump_r     <= '0;
            g_dump_r     <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else if (!enable) begin
            count_r      <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            result_valid <= dump_s;
            if (dump_s) begin
                overflow <= overflow | clip_re_s | clip_im_s;
            end else begin
                overflow <= overflow;
            end
            if (state_r == IDLE) begin
                count_r <= '0;
                k_r     <= lia_clamp_log2(avg_log2);
                g_r     <= gain_shift;
            end else if (win_end_s) begin
                // Hand this window's shifts to DUMP; new window takes fresh settings.
                count_r  <= '0;
                k_dump_r <= k_r;
                g_dump_r <= g_r;
                k_r      <= lia_clamp_log2(avg_log2);
                g_r      <= gain_shift;
            end else if (acc_add_s) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    lia_mac_channel u_sine (
        .clk      (clk),
        .rst      (rst),
        .adc_data (adc_data),
        .ref_data (sine_ref),
        .acc_add  (acc_add_s),
        .win_end  (win_end_s),
        .acc_clr  (acc_clr_s),
        .dump     (dump_s),
        .k_dump   (k_dump_r),
        .g_dump   (g_dump_r),
        .comp     (real_comp),
        .clip     (clip_re_s)
    );

    lia_mac_channel u_cos (
        .clk      (clk),
        .rst      (rst),
        .adc_data (adc_data),
        .ref_data (cos_ref),
        .acc_add  (acc_add_s),
        .win_end  (win_end_s),
        .acc_clr  (acc_clr_s),
        .dump     (dump_s),
        .k_dump   (k_dump_r),
        .g_dump   (g_dump_r),
        .comp     (imag_comp),
        .clip     (clip_im_s)
    );

endmodule

// File: tb/tb_lock_in_integrator.sv
// -----------------------------------------------------------------------------
// tb_lock_in_integrator
// Directed-vector bench for lock_in_integrator. Inputs change on the falling
// edge; a falling-edge monitor records every result_valid pulse with its cycle
// number and output values.
// -----------------------------------------------------------------------------
module tb_lock_in_integrator;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               sample_valid;
    logic signed [15:0] adc_data;
    logic signed [15:0] sine_ref;
    logic signed [15:0] cos_ref;
    logic [4:0]         avg_log2;
    logic [3:0]         gain_shift;
    logic signed [31:0] real_comp;
    logic signed [31:0] imag_comp;
    logic               result_valid;
    logic               overflow;

    int     tests_run    = 0;
    int     tests_failed = 0;
    int     cyc          = 0;
    int     last_c;
    int     c_a;
    int     c_b;
    int     rv_cyc[$];
    longint rv_re[$];
    longint rv_im[$];
    longint exp_clip;

    lock_in_integrator dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .adc_data     (adc_data),
        .sine_ref     (sine_ref),
        .cos_ref      (cos_ref),
        .avg_log2     (avg_log2),
        .gain_shift   (gain_shift),
        .real_comp    (real_comp),
        .imag_comp    (imag_comp),
        .result_valid (result_valid),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Cycle counter: number of rising edges seen so far.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Record every result pulse.
    always @(negedge clk) begin
        if (result_valid) begin
            rv_cyc.push_back(cyc);
            rv_re.push_back(real_comp);
            rv_im.push_back(imag_comp);
        end
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one valid sample for one cycle (called on a falling edge).
    task automatic send(input int a, input int s, input int c);
        adc_data     = 16'(a);
        sine_ref     = 16'(s);
        cos_ref      = 16'(c);
        sample_valid = 1'b1;
        last_c       = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        rv_cyc.delete();
        rv_re.delete();
        rv_im.delete();
    endtask

    task automatic restart();
        enable = 1'b0;
        idle(2);
        clear_log();
    endtask

    initial begin
`ifdef LIA_SATURATE_EN
        exp_clip = 64'sd2147483647;
`else
        exp_clip = -64'sd2147483648;
`endif
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        adc_data     = 16'sd0;
        sine_ref     = 16'sd0;
        cos_ref      = 16'sd0;
        avg_log2     = 5'd2;
        gain_shift   = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_real", real_comp, 0);
        check_eq("reset_imag", imag_comp, 0);
        check_eq("reset_valid", result_valid, 0);
        check_eq("reset_ovf", overflow, 0);
        rst = 1'b0;
        idle(2);

        // Constant inputs, window of 4, three back-to-back windows.
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(1000, 2000, -500);
            if (i == 3) c_a = last_c;
        end
        idle(8);
        check_eq("t1_pulses", rv_cyc.size(), 3);
        if (rv_cyc.size() >= 3) begin
            check_eq("t1_latency", rv_cyc[0] - c_a, 4);
            check_eq("t1_period1", rv_cyc[1] - rv_cyc[0], 4);
            check_eq("t1_period2", rv_cyc[2] - rv_cyc[1], 4);
            check_eq("t1_real0", rv_re[0], 2000000);
            check_eq("t1_imag0", rv_im[0], -500000);
            check_eq("t1_real2", rv_re[2], 2000000);
        end
        check_eq("t1_ovf", overflow, 0);
        restart();

        // Floor rounding of a negative mean: products -1,-1,-1,0 / +1,+1,+1,0.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) send(1, -1, 1);
        send(0, -1, 1);
        idle(8);
        check_eq("t2_pulses", rv_cyc.size(), 1);
        if (rv_cyc.size() >= 1) begin
            check_eq("t2_real_floor", rv_re[0], -1);
            check_eq("t2_imag_floor", rv_im[0], 0);
        end
        restart();

        // Extreme product with gain: 2^30 << 1 exceeds the output range.
        avg_log2   = 5'd0;
        gain_shift = 4'd1;
        enable     = 1'b1;
        send(-32768, -32768, 0);
        c_a = last_c;
        idle(8);
        check_eq("t3_pulses", rv_cyc.size(), 1);
        if (rv_cyc.size() >= 1) begin
            check_eq("t3_latency", rv_cyc[0] - c_a, 4);
            check_eq("t3_real_clip", rv_re[0], exp_clip);
            check_eq("t3_imag", rv_im[0], 0);
        end
        check_eq("t3_ovf_set", overflow, 1);
        restart();
        check_eq("t3_ovf_clear", overflow, 0);
        check_eq("t3_real_hold", real_comp, exp_clip);

        // Window size change mid-window applies at the next boundary.
        gain_shift = 4'd0;
        avg_log2   = 5'd2;
        enable     = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 3) avg_log2 = 5'd3;
            send(1, i, 3);
            if (i == 4)  c_a = last_c;
            if (i == 12) c_b = last_c;
        end
        idle(10);
        check_eq("t4_pulses", rv_cyc.size(), 2);
        if (rv_cyc.size() >= 2) begin
            check_eq("t4_end_first", rv_cyc[0] - c_a, 4);
            check_eq("t4_end_second", rv_cyc[1] - c_b, 4);
            check_eq("t4_real0", rv_re[0], 2);
            check_eq("t4_imag0", rv_im[0], 3);
            check_eq("t4_real1", rv_re[1], 8);
            check_eq("t4_imag1", rv_im[1], 3);
        end
        restart();

        // Abort a window with enable low: no pulse, outputs hold.
        avg_log2 = 5'd2;
        enable   = 1'b1;
        for (int i = 0; i < 3; i++) send(5, 5, 5);
        enable = 1'b0;
        idle(8);
        check_eq("t5_no_pulse", rv_cyc.size(), 0);
        check_eq("t5_real_hold", real_comp, 8);
        check_eq("t5_imag_hold", imag_comp, 3);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) send(10, 7, -3);
        idle(8);
        check_eq("t5_pulses", rv_cyc.size(), 1);
        if (rv_cyc.size() >= 1) begin
            check_eq("t5_real", rv_re[0], 70);
            check_eq("t5_imag", rv_im[0], -30);
        end
        clear_log();

        // Asynchronous reset mid-window with toggling sample_valid.
        send(4, 4, 4);
        idle(1);
        send(4, 4, 4);
        #1 rst = 1'b1;
        #1;
        check_eq("t6_rst_real", real_comp, 0);
        check_eq("t6_rst_imag", imag_comp, 0);
        check_eq("t6_rst_valid", result_valid, 0);
        check_eq("t6_rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_no_pulse", rv_cyc.size(), 0);
        clear_log();
        for (int i = 0; i < 4; i++) begin
            send(2, 3, 5);
            idle(1);
        end
        idle(8);
        check_eq("t6_pulses", rv_cyc.size(), 1);
        if (rv_cyc.size() >= 1) begin
            check_eq("t6_real", rv_re[0], 6);
            check_eq("t6_imag", rv_im[0], 10);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lock_in_integrator.md
# lock_in_integrator

Demodulation and averaging stage that sits directly downstream of the lock-in amplifier's reference generator. It multiplies each ADC sample by the in-phase (sine) and quadrature (cosine) reference words. It accumulates both products over a window of 2^avg_log2 valid samples and publishes the window means as signed real/imag components with a one-cycle valid strobe. These components feed the OPO lock servo's error computation.

## Interface
- WORD_W, 16, signed width of ADC and reference samples (package word_width)
- OUT_W, 32, signed width of real/imag outputs (package config_reg_width)
- MAX_LOG2, 16, largest accepted avg_log2
- clk  in  1  system clock (250 MHz)
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  1 = integrate; 0 = abort window, clear accumulators
- sample_valid  in  1  qualifies adc_data/sine_ref/cos_ref this cycle
- adc_data  in  WORD_W  signed ADC sample
- sine_ref  in  WORD_W  signed in-phase reference
- cos_ref  in  WORD_W  signed quadrature reference
- avg_log2  in  5  window = 2^avg_log2 samples; values > MAX_LOG2 clamp to MAX_LOG2
- gain_shift  in  4  left shift applied to window mean, 0..15
- real_comp  out  OUT_W  signed in-phase mean × 2^gain_shift
- imag_comp  out  OUT_W  signed quadrature mean × 2^gain_shift
- result_valid  out  1  one-cycle pulse when real/imag update
- overflow  out  1  sticky; set when any output was clipped/wrapped, cleared only by rst or enable low

## Operation
- Pipeline per channel: S1 registers inputs+valid; S2 signed WORD_W×WORD_W product (2·WORD_W bits); S3 accumulate into 2·WORD_W+MAX_LOG2-bit signed accumulator.
- FSM states IDLE, ACCUM, DUMP.
  - IDLE: accumulators and counter zero; on enable=1 latch avg_log2 (clamped) -> ACCUM.
  - ACCUM: each valid product at S3 adds to acc, count++. When count reaches 2^k-1 and a valid product arrives, the final sum goes to DUMP; acc reloads to 0 the same cycle (next window starts cleanly, no sample lost). With k=0, every valid sample is its own window.
  - DUMP: compute mean = sum >>> k (arithmetic, floor toward -inf). Then scaled = mean << gain_shift. Register the outputs, pulse result_valid, relatch avg_log2, then return to ACCUM. A valid product arriving during DUMP is accumulated into the new window.
- avg_log2/gain_shift changes mid-window take effect at the next window boundary (latched at window start).
- enable falling: pipeline valids and accumulators clear next cycle; the in-flight window is discarded without a result_valid; real/imag hold their last values; overflow clears; FSM -> IDLE.
- Products −2^(W−1)·−2^(W−1) = 2^(2W−2) are representable; the accumulator cannot overflow for k ≤ MAX_LOG2.

## Timing
- Reset: real_comp=0, imag_comp=0, result_valid=0, overflow=0, FSM=IDLE, all pipeline valids 0.
- Latency: the last window sample presented at cycle t gives result_valid=1 at t+4 (S1 t+1, S2 t+2, S3/accumulate t+3, DUMP output t+4).
- Back-to-back windows: sustained throughput of one sample per cycle, with no stalls.
- Reset mid-window: immediate asynchronous clear; no pulse.

## Configuration
- LIA_SATURATE_EN defined: if scaled exceeds OUT_W signed range, the output clamps to +2^(OUT_W−1)−1 / −2^(OUT_W−1) and overflow is set.
- Undefined: the output is the low OUT_W bits (two's-complement wrap); overflow is still set whenever wrap occurred.

## Structure
- opo_package gains lia_state_t (IDLE/ACCUM/DUMP enum) and LIA_MAX_LOG2. It reuses the existing word_width and config_reg_width.
- Sub-module lia_mac_channel (multiply, accumulate, shift, saturate), instantiated twice (sine, cosine). FSM and counter are shared in the top.

## Test plan
- avg_log2=2, gain_shift=0, adc=1000, sine=2000, cos=−500, valid every cycle -> real=2_000_000, imag=−500_000, result_valid exactly 4 cycles after the 4th sample, then every 4 cycles.
- avg_log2=2, products −1,−1,−1,0 -> real=−1 (floor).
- adc=sine=−32768, avg_log2=0, gain_shift=1 -> real=2^31 clipped to 2147483647 with overflow=1 (LIA_SATURATE_EN); wraps to −2147483648 with overflow=1 without it.
- Change avg_log2 2→3 after 2 samples -> first window still ends after 4 samples; the next ends after 8.
- Drop enable after 3 of 4 samples -> no result_valid; outputs hold; re-enable plus 4 samples -> fresh correct mean.
- Assert rst during ACCUM with sample_valid toggling -> all outputs 0 immediately; first result after release is computed from post-reset samples only.
